// File: rtl/bus_pkg.sv
// Shared data-bus definitions for the data bus responder and the
// data_memory_interface verification models.
//   BUS_ADDR_W / BUS_DATA_W / BUS_BE_W : bus field widths
//   MAX_WAIT_STATES / MAX_READ_LATENCY : upper bounds for responder timing
//   bus_req_t : one initiator request beat
//   bus_rsp_t : one responder response beat
//   merge_bytes() : lane-masked word update used for byte-enabled writes
package bus_pkg;

  localparam int BUS_ADDR_W       = 32;
  localparam int BUS_DATA_W       = 32;
  localparam int BUS_BE_W         = 4;
  localparam int MAX_WAIT_STATES  = 15;
  localparam int MAX_READ_LATENCY = 4;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] address;
    logic [BUS_DATA_W-1:0] write_data;
    logic [BUS_BE_W-1:0]   byte_enable;
    logic                  read_enable;
    logic                  write_enable;
  } bus_req_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] read_data;
    logic                  valid;
    logic                  wait_req;
  } bus_rsp_t;

  // Replace only the bytes whose lane enable is set.
  function automatic logic [BUS_DATA_W-1:0] merge_bytes(
    input logic [BUS_DATA_W-1:0] old_word,
    input logic [BUS_DATA_W-1:0] new_word,
    input logic [BUS_BE_W-1:0]   lanes
  );
    logic [BUS_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BUS_BE_W; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_responder_read_pipe.sv
// Fixed-latency read return pipe for the data bus responder.
// A {valid, data} shift register LATENCY stages deep. Data is forced to
// zero on entry whenever the slot is empty, so every stage (and therefore
// the output) carries zero data outside its valid cycle.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low clear of all stages
//   in_valid  : read accepted this edge
//   in_data   : word read from memory on the accept edge
//   out_valid : one-cycle pulse LATENCY cycles after acceptance
//   out_data  : returned word, zero when out_valid==0
module responder_read_pipe
  import bus_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BUS_DATA_W-1:0] in_data,
  output logic                  out_valid,
  output logic [BUS_DATA_W-1:0] out_data
);

  logic                  vld_p [LATENCY];
  logic [BUS_DATA_W-1:0] dat_p [LATENCY];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        dat_p[i] <= '0;
      end
    end else begin
      // stage p0: capture on the accept edge
      vld_p[0] <= in_valid;
      dat_p[0] <= in_valid ? in_data : '0;
      // stages p1..: pure delay
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        dat_p[i] <= dat_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[LATENCY-1];
  assign out_data  = dat_p[LATENCY-1];

endmodule

// File: rtl/data_bus_responder.sv
// Memory-backed data bus slave with an address window, programmable wait
// states and a fixed read latency.
//   clock            : rising-edge clock
//   reset            : asynchronous active-low; memory contents survive it
//   bus_address      : byte address, bits [1:0] ignored
//   bus_write_data   : lane-aligned write data
//   bus_byte_enable  : write lane mask
//   bus_read_enable  : read request, held until accepted
//   bus_write_enable : write request, held until accepted
//   bus_wait_req     : combinational stall for in-window requests
//   bus_read_data    : read data, zero outside the valid cycle
//   bus_valid        : one pulse per accepted in-window read
//   access_fault     : one pulse after an out-of-window access is accepted
module data_bus_responder
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          WAIT_STATES  = 0,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BUS_ADDR_W-1:0] bus_address,
  input  logic [BUS_DATA_W-1:0] bus_write_data,
  input  logic [BUS_BE_W-1:0]   bus_byte_enable,
  input  logic                  bus_read_enable,
  input  logic                  bus_write_enable,
  output logic                  bus_wait_req,
  output logic [BUS_DATA_W-1:0] bus_read_data,
  output logic                  bus_valid,
  output logic                  access_fault
);

  localparam int         DEPTH      = 2**ADDR_WIDTH;
  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

  bus_req_t              req_s;
  logic                  req;
  logic                  hit;
  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            wcnt;
  logic [BUS_DATA_W-1:0] mem [DEPTH];
  logic                  addr_lsb_unused;

  assign req_s = '{address:      bus_address,
                   write_data:   bus_write_data,
                   byte_enable:  bus_byte_enable,
                   read_enable:  bus_read_enable,
                   write_enable: bus_write_enable};

  assign addr_lsb_unused = ^req_s.address[1:0];

  assign req      = req_s.read_enable | req_s.write_enable;
  assign hit      = (req_s.address[31:2+ADDR_WIDTH] == BASE_ADDR[31:2+ADDR_WIDTH]);
  assign word_idx = req_s.address[ADDR_WIDTH+1:2];

  // Out-of-window requests never stall, so they are accepted at once.
  assign bus_wait_req = req & hit & (wcnt != WAIT_LIMIT);
  assign accept       = req & ~bus_wait_req;
  assign wr_accept    = accept & hit & req_s.write_enable;
  // A simultaneous read+write performs only the write.
  assign rd_accept    = accept & hit & req_s.read_enable & ~req_s.write_enable;

  // Counting only while stalled also clears the counter on accept and
  // when the initiator drops its request early.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt <= 4'd0;
    end else if (bus_wait_req) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      access_fault <= 1'b0;
    end else begin
      access_fault <= accept & ~hit;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[word_idx] <= merge_bytes(mem[word_idx], req_s.write_data, req_s.byte_enable);
    end
  end

  responder_read_pipe #(
    .LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (rd_accept),
    .in_data  (mem[word_idx]),
    .out_valid(bus_valid),
    .out_data (bus_read_data)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;
  import bus_pkg::*;

  localparam int N = 4;
  localparam int WS_T  [N] = '{0, 3, 0, 0};
  localparam int LAT_T [N] = '{1, 2, 3, 4};

  logic        clock = 1'b0;
  logic        rst_n [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [3:0]  be    [N];
  logic        re    [N];
  logic        we    [N];
  logic        wreq  [N];
  logic [31:0] rdata [N];
  logic        vld   [N];
  logic        flt   [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_bus_responder #(
      .BASE_ADDR   (32'h0001_0000),
      .ADDR_WIDTH  (10),
      .WAIT_STATES (WS_T[g]),
      .READ_LATENCY(LAT_T[g])
    ) u_dut (
      .clock           (clock),
      .reset           (rst_n[g]),
      .bus_address     (addr[g]),
      .bus_write_data  (wdata[g]),
      .bus_byte_enable (be[g]),
      .bus_read_enable (re[g]),
      .bus_write_enable(we[g]),
      .bus_wait_req    (wreq[g]),
      .bus_read_data   (rdata[g]),
      .bus_valid       (vld[g]),
      .access_fault    (flt[g])
    );
  end

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          g;
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every bus_valid must match the oldest expected read, in
  // the cycle it is due; an expectation whose cycle passes is a miss.
  always @(negedge clock) begin
    for (int g = 0; g < N; g++) begin
      if (vld[g] === 1'b1) begin
        if (sb.size() == 0 || sb[0].g != g) begin
          chk($sformatf("unexp_valid_u%0d", g), 32'(vld[g]), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("rd_data_u%0d", g), rdata[g], e.d);
          chk($sformatf("rd_cycle_u%0d", g), 32'(cyc), 32'(e.due));
        end
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("missed_valid_u%0d", e.g), 32'(vld[e.g]), 32'd1);
    end
  end

  // Drive one request, count stall cycles, and return just after the
  // accept edge with the request withdrawn.
  task automatic do_req(input int g, input logic [31:0] a, input logic r, input logic w,
                        input logic [3:0] b, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit push);
    int n;
    bit in_win;
    n      = 0;
    in_win = (a[31:12] == 20'h00010);
    addr[g]  = a;
    wdata[g] = d;
    be[g]    = b;
    re[g]    = r;
    we[g]    = w;
    @(negedge clock);
    while (wreq[g] === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
    end
    chk($sformatf("wait_cycles_u%0d", g), 32'(n), 32'(in_win ? WS_T[g] : 0));
    if (push && r && !w && in_win) sb.push_back('{g, exp_rd, cyc + LAT_T[g]});
    @(posedge clock);
    #1;
    re[g] = 1'b0;
    we[g] = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int g = 0; g < N; g++) begin
      rst_n[g] = 1'b0;
      addr[g]  = '0;
      wdata[g] = '0;
      be[g]    = '0;
      re[g]    = 1'b0;
      we[g]    = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_valid_u%0d", g), 32'(vld[g]), 32'd0);
      chk($sformatf("rst_rdata_u%0d", g), rdata[g], 32'd0);
      chk($sformatf("rst_fault_u%0d", g), 32'(flt[g]), 32'd0);
      chk($sformatf("rst_wreq_u%0d", g), 32'(wreq[g]), 32'd0);
    end
    @(posedge clock);
    #1;
    for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
    idle(1);

    // u0: full write then read back
    do_req(0, 32'h0001_0010, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req(0, 32'h0001_0010, 1'b1, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    // u0: single-lane write over an existing word
    do_req(0, 32'h0001_0014, 1'b0, 1'b1, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    do_req(0, 32'h0001_0014, 1'b0, 1'b1, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0);
    do_req(0, 32'h0001_0014, 1'b1, 1'b0, 4'h0, 32'h0, 32'h1122_33AA, 1'b1);
    // u0: read+write together performs only the write
    do_req(0, 32'h0001_0020, 1'b1, 1'b1, 4'hF, 32'h5566_7788, 32'h0, 1'b1);
    do_req(0, 32'h0001_0020, 1'b1, 1'b0, 4'h0, 32'h0, 32'h5566_7788, 1'b1);
    // u0: out-of-window read and write fault and leave memory alone
    do_req(0, 32'h0001_0100, 1'b0, 1'b1, 4'hF, 32'hCAFE_0000, 32'h0, 1'b0);
    do_req(0, 32'h0000_0100, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clock);
    chk("fault_pulse_rd", 32'(flt[0]), 32'd1);
    @(negedge clock);
    chk("fault_clear_rd", 32'(flt[0]), 32'd0);
    idle(1);
    do_req(0, 32'h0000_0100, 1'b0, 1'b1, 4'hF, 32'h0000_0001, 32'h0, 1'b0);
    @(negedge clock);
    chk("fault_pulse_wr", 32'(flt[0]), 32'd1);
    idle(1);
    do_req(0, 32'h0001_0100, 1'b1, 1'b0, 4'h0, 32'h0, 32'hCAFE_0000, 1'b1);
    idle(6);

    // u1: three wait states, latency two; an abandoned request must not
    // leave the stall count part-way.
    do_req(1, 32'h0001_0040, 1'b0, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
    addr[1] = 32'h0001_0040;
    re[1]   = 1'b1;
    @(negedge clock);
    chk("stall_seen_u1", 32'(wreq[1]), 32'd1);
    @(posedge clock);
    #1;
    re[1] = 1'b0;
    idle(1);
    do_req(1, 32'h0001_0040, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b1);
    idle(6);

    // u2: back-to-back reads of words 0..3, latency three
    for (int i = 0; i < 4; i++)
      do_req(2, 32'h0001_0000 + 32'(4*i), 1'b0, 1'b1, 4'hF, 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      do_req(2, 32'h0001_0000 + 32'(4*i), 1'b1, 1'b0, 4'h0, 32'h0, 32'(i), 1'b1);
    idle(8);

    // u3: reset two cycles after a latency-four read flushes it
    do_req(3, 32'h0001_0080, 1'b0, 1'b1, 4'hF, 32'h5A5A_A5A5, 32'h0, 1'b0);
    do_req(3, 32'h0001_0080, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    rst_n[3] = 1'b0;
    @(negedge clock);
    chk("midrst_valid_u3", 32'(vld[3]), 32'd0);
    chk("midrst_rdata_u3", rdata[3], 32'd0);
    @(posedge clock);
    #1;
    rst_n[3] = 1'b1;
    idle(8);
    do_req(3, 32'h0001_0080, 1'b1, 1'b0, 4'h0, 32'h0, 32'h5A5A_A5A5, 1'b1);
    idle(8);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
